coef_load_ctrl: RTL

COEF_LOAD_CTRL -- requirements
Module: coef_load_ctrl

---
 rtl/fir_pkg.sv | 20 ++
 rtl/coef_load_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR filter constants and coefficient-load state encoding
package fir_pkg;

  localparam int FIR_IN_W       = 16;
  localparam int FIR_OUT_W      = 24;
  localparam int FIR_NUM_LUTS   = 8;
  localparam int FIR_LUT_DEPTH  = 256;
  localparam int FIR_NUM_WORDS  = FIR_NUM_LUTS * FIR_LUT_DEPTH;
  localparam int FIR_ADDR_W     = 11;
  localparam int FIR_DATA_W     = 19;
  localparam int FIR_SETTLE_CYC = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_LOAD      = 2'd2,
    ST_SETTLE    = 2'd3
  } coef_state_e;

endpackage

// File: rtl/coef_load_ctrl.sv
// rtl/coef_load_ctrl.sv - streams a coefficient set into the DA LUTs while holding the filter
module coef_load_ctrl
  import fir_pkg::*;
#(
  parameter int NUM_WORDS  = FIR_NUM_WORDS,
  parameter int ADDR_W     = FIR_ADDR_W,
  parameter int DATA_W     = FIR_DATA_W,
  parameter int SETTLE_CYC = FIR_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              cfg_ready,
  input  logic              da_busy,
  output logic [DATA_W-1:0] CIN,
  output logic [ADDR_W-1:0] CADDR,
  output logic              CLOAD,
  output logic              filter_hold,
  output logic              coef_valid,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  coef_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cin_q, cin_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic              cload_q, cload_d;
  logic              coef_valid_q, coef_valid_d;
  logic              good_q, good_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              accept;

  assign accept = (state_q == ST_LOAD) && cfg_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      cin_q        <= '0;
      caddr_q      <= '0;
      cload_q      <= 1'b0;
      coef_valid_q <= 1'b0;
      good_q       <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      cin_q        <= cin_d;
      caddr_q      <= caddr_d;
      cload_q      <= cload_d;
      coef_valid_q <= coef_valid_d;
      good_q       <= good_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    cin_d        = cin_q;
    caddr_d      = caddr_q;
    cload_d      = 1'b0;
    coef_valid_d = coef_valid_q;
    good_d       = good_q;
    load_done_d  = 1'b0;
    load_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        // The old set is still intact until the first write, so coef_valid falls only here.
        if (!da_busy) begin
          state_d      = ST_LOAD;
          idx_d        = '0;
          coef_valid_d = 1'b0;
          good_d       = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          cload_d = 1'b1;
          cin_d   = cfg_data;
          caddr_d = idx_q;
          if (idx_q == LAST_IDX) begin
            // A full set ends the load either way; missing cfg_last means a long load.
            state_d    = ST_SETTLE;
            cnt_d      = '0;
            good_d     = cfg_last;
            load_err_d = !cfg_last;
          end else if (cfg_last) begin
            state_d    = ST_SETTLE;
            cnt_d      = '0;
            good_d     = 1'b0;
            load_err_d = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          load_done_d  = good_q;
          coef_valid_d = good_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cfg_ready   = (state_q == ST_LOAD);
  assign filter_hold = (state_q != ST_IDLE) || !coef_valid_q;
  assign CIN         = cin_q;
  assign CADDR       = caddr_q;
  assign CLOAD       = cload_q;
  assign coef_valid  = coef_valid_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;

endmodule
